// File: rtl/reg_xfer_sched_if.sv
// Request/grant and register-bus strobe bundle between the bus scheduler and
// its requesters (master side) / the scheduler itself (slave side).
interface reg_xfer_sched_if #(
  parameter int NREQ = 4,
  parameter int NREG = 8
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_src;
  logic [3*NREQ-1:0] req_dst;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREG-1:0]   src_oe;
  logic [NREG-1:0]   dst_latch;
  logic              busy;

  modport master (
    output req, req_src, req_dst,
    input  gnt, done, src_oe, dst_latch, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output gnt, done, src_oe, dst_latch, busy
  );
endinterface

// File: rtl/reg_xfer_sched.sv
// Internal data-bus transfer scheduler: round-robin arbitration, then DRIVE/LATCH sequencing.
// Optional macro REG_XFER_PRIO0_EN gives requester 0 absolute priority over the round-robin.

// Per-requester slice: contributes its index and src/dst fields to an OR chain
// when it is the one-hot winner, so the top never needs a variable index.
module reg_xfer_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic          hit,
  input  logic [2:0]    src,
  input  logic [2:0]    dst,
  input  logic [PW-1:0] win_i,
  input  logic [2:0]    src_i,
  input  logic [2:0]    dst_i,
  output logic [PW-1:0] win_o,
  output logic [2:0]    src_o,
  output logic [2:0]    dst_o
);
  assign win_o = win_i | (hit ? PW'(IDX) : '0);
  assign src_o = src_i | (hit ? src : 3'd0);
  assign dst_o = dst_i | (hit ? dst : 3'd0);
endmodule

module reg_xfer_sched #(
  parameter int NREQ = 4,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst,
  reg_xfer_sched_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, LATCH = 2'd2} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr, cur_req, win, rr_next;
  logic [2:0]          cur_src, cur_dst, win_src, win_dst;
  logic [NREQ-1:0]     rot, rot_lo, oh_rr, win_oh, gnt_c;
  logic [NREQ:0][PW-1:0] win_c;
  logic [NREQ:0][2:0]  src_c, dst_c;
  logic                found, arb_en, degen;
  logic [NREG-1:0]     src_oe_q, dst_latch_q;
  logic [NREQ-1:0]     done_q;
  logic                busy_q;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  assign rot    = NREQ'({bus.req, bus.req} >> rr_ptr);
  assign rot_lo = rot & (~rot + 1'b1);
  assign oh_rr  = NREQ'(({rot_lo, rot_lo} << rr_ptr) >> NREQ);

`ifdef REG_XFER_PRIO0_EN
  assign win_oh = bus.req[0] ? NREQ'(1) : oh_rr;
`else
  assign win_oh = oh_rr;
`endif

  assign win_c[0] = '0;
  assign src_c[0] = '0;
  assign dst_c[0] = '0;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    reg_xfer_lane #(.PW(PW), .IDX(i)) u_lane (
      .hit   (win_oh[i]),
      .src   (bus.req_src[3*i +: 3]),
      .dst   (bus.req_dst[3*i +: 3]),
      .win_i (win_c[i]),
      .src_i (src_c[i]),
      .dst_i (dst_c[i]),
      .win_o (win_c[i+1]),
      .src_o (src_c[i+1]),
      .dst_o (dst_c[i+1])
    );
  end

  assign win     = win_c[NREQ];
  assign win_src = src_c[NREQ];
  assign win_dst = dst_c[NREQ];
  assign found   = |bus.req;
  assign degen   = (win_src == win_dst);
  assign rr_next = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
  assign arb_en  = !rst && found && (state == IDLE || state == LATCH);
  assign gnt_c   = arb_en ? win_oh : '0;

  assign bus.gnt       = gnt_c;
  // A src==dst request completes in its own grant cycle, outside the FSM.
  assign bus.done      = done_q | (degen ? gnt_c : '0);
  assign bus.src_oe    = src_oe_q;
  assign bus.dst_latch = dst_latch_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_req     <= '0;
      cur_src     <= '0;
      cur_dst     <= '0;
      src_oe_q    <= '0;
      dst_latch_q <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      src_oe_q    <= '0;
      dst_latch_q <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      case (state)
        DRIVE: begin
          state       <= LATCH;
          src_oe_q    <= NREG'(1) << cur_src;
          dst_latch_q <= NREG'(1) << cur_dst;
          done_q      <= NREQ'(1) << cur_req;
          busy_q      <= 1'b1;
        end
        default: begin
          state <= IDLE;
          if (arb_en) begin
`ifdef REG_XFER_PRIO0_EN
            if (win != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
            cur_req <= win;
            cur_src <= win_src;
            cur_dst <= win_dst;
            if (!degen) begin
              state    <= DRIVE;
              src_oe_q <= NREG'(1) << win_src;
              busy_q   <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
